a3_pipelined_control_unit: RTL and testbench
============================================

# a3_pipelined_control_unit

Parametrised, pipelined successor to the single-cycle control unit of the li/add/j datapath. Decodes the opcode in ID and carries the control bits through EX and WB pipeline registers. Generates jump redirect with a one-instruction squash, external stall handling and operand-forwarding selects for ADD. Maintains a wrapping retired-instruction counter. Sits between the IF/ID register and the datapath stage muxes.

## Interface
- OPW, 3, opcode width (≥2; only bits [1:0] decoded, upper bits must be 0 for a legal opcode)
- RW, 3, register-address width
- CNTW, 16, retired-instruction counter width

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- instr_valid  in  1  ID holds a valid instruction
- opcode  in  OPW  instruction opcode
- rd, rs1, rs2  in  RW each  destination/source register fields
- stall_in  in  1  downstream stall request
- hold_out  out  1  upstream must hold IF/ID (= stall_in)
- PCSrc  out  1  ID-stage jump redirect (combinational)
- ex_valid, ex_SEtoReg, ex_WriteReg  out  1 each  EX-stage control
- ex_rd  out  RW  EX destination
- ex_fwd_a, ex_fwd_b  out  2 each  operand selects: 00 regfile, 01 from EX result, 10 from WB result
- wb_valid, wb_SEtoReg, wb_WriteReg  out  1 each  WB-stage control
- wb_rd  out  RW  WB destination
- retired  out  CNTW  count of instructions leaving WB

## Operation
- Decode (opcode): LI 000 → SEtoReg=1, WriteReg=1; ADD 001 → SEtoReg=0, WriteReg=1; J 011 → PCSrc=1, WriteReg=0, SEtoReg=0; any other value → NOP (all 0, valid still propagates).
- Instruction accepted in ID when instr_valid=1, stall_in=0, squash=0.
- PCSrc = accepted & (opcode==J).
- squash flag: set on accepted J. Cleared on the next cycle with instr_valid=1 and stall_in=0; that instruction becomes a bubble (no PCSrc, ex_valid=0). Held through stall cycles.
- Stall: stall_in=1 → EX loads a bubble (all EX outputs 0), WB advances normally, hold_out=1.
- Forwarding (ADD only, else 00): per source, rsX==ex_rd & ex_WriteReg & ex_valid → 01; else rsX==wb_rd & wb_WriteReg & wb_valid → 10; else 00. EX has priority. Register 0 is not special.
- retired increments on every cycle with wb_valid=1, wraps 2^CNTW−1 → 0.

## Timing
- Reset: all ex_*/wb_* outputs 0, retired 0, squash 0; PCSrc and hold_out follow inputs (0 when squash=0 and inputs idle).
- Latency: instruction accepted at cycle t → ex_* at t+1 → wb_* at t+2 → retired incremented visible at t+3.
- Fwd selects are registered into EX with the instruction; computed from EX/WB state in cycle t.
- J during stall: PCSrc held 0 until the cycle stall_in drops.
- Reset mid-operation: all in-flight instructions and a pending squash are discarded; counter cleared.
- stall_in with squash pending and instr_valid=1: squash not consumed.

## Structure
- Package a3_cpu_pkg: opcode constants (OP_LI, OP_ADD, OP_J), forward-select constants (FWD_RF, FWD_EX, FWD_WB), ctrl struct {SEtoReg, WriteReg, PCSrc}.
- Sub-module a3_decode: combinational opcode → ctrl struct, parametrised by OPW.
- Top holds squash flag, EX/WB registers, forwarding compare, counter.

## Test plan
- Reset then LI r1, ADD r2←r1,r1, cycles 0-1 → ADD ex_fwd_a=01, ex_fwd_b=01; wb_rd=2, wb_WriteReg=1 at cycle 3.
- LI r3, NOP, ADD r4←r3,r0 → ex_fwd_a=10, ex_fwd_b=00.
- J at cycle 0, LI r5 at cycle 1 → PCSrc=1 at 0; LI squashed: ex_valid=0 at 2, wb never shows rd=5; retired counts 1 (the J only).
- J then stall_in=1 for 3 cycles, LI presented throughout → squash held; LI bubbled when stall drops; hold_out=1 during stall.
- CNTW=4, 17 back-to-back LIs → retired wraps to 1.
- rst_n=0 with ADD in EX and squash pending → next cycle all ex_*/wb_* 0, retired 0; next valid instruction not squashed.

Source files
------------

// File: rtl/a3_cpu_pkg.sv
// Shared encodings and the control bundle for the pipelined li/add/j control unit.
package a3_cpu_pkg;

    // Opcode values on the two decoded bits; upper opcode bits must be zero.
    localparam logic [1:0] OP_LI  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_J   = 2'b11;

    // Operand source selects driven toward the EX operand muxes.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // Control bits produced by the ID-stage decoder.
    typedef struct packed {
        logic SEtoReg;
        logic WriteReg;
        logic PCSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{SEtoReg: 1'b0, WriteReg: 1'b0, PCSrc: 1'b0};

    // The younger producer (EX) wins over the older one (WB).
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/a3_decode.sv
// ID-stage opcode decoder: opcode -> control bundle. Only bits [1:0] carry meaning;
// any opcode with a nonzero upper bit is treated as a NOP.
module a3_decode
    import a3_cpu_pkg::*;
#(
    parameter int OPW = 3
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl,
    output logic           is_add
);

    logic upper_zero;

    // Shifting out the decoded bits leaves only the bits that must be zero.
    assign upper_zero = ((opcode >> 2) == '0);

    // Map legal opcodes to their control bits; everything else decodes as NOP.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        ctrl   = CTRL_NOP;
        is_add = 1'b0;
        if (upper_zero) begin
            case (opcode[1:0])
                OP_LI: begin
                    ctrl.SEtoReg  = 1'b1;
                    ctrl.WriteReg = 1'b1;
                end
                OP_ADD: begin
                    ctrl.WriteReg = 1'b1;
                    is_add        = 1'b1;
                end
                OP_J: begin
                    ctrl.PCSrc = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/a3_pipelined_control_unit.sv
// Pipelined control unit: decodes in ID, carries control through EX and WB
// registers, redirects on J with a one-instruction squash, honours an external
// stall, produces operand-forwarding selects for ADD and counts retirements.
module a3_pipelined_control_unit
    import a3_cpu_pkg::*;
#(
    parameter int OPW  = 3,
    parameter int RW   = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [OPW-1:0]  opcode,
    input  logic [RW-1:0]   rd,
    input  logic [RW-1:0]   rs1,
    input  logic [RW-1:0]   rs2,
    input  logic            stall_in,
    output logic            hold_out,
    output logic            PCSrc,
    output logic            ex_valid,
    output logic            ex_SEtoReg,
    output logic            ex_WriteReg,
    output logic [RW-1:0]   ex_rd,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic            wb_valid,
    output logic            wb_SEtoReg,
    output logic            wb_WriteReg,
    output logic [RW-1:0]   wb_rd,
    output logic [CNTW-1:0] retired
);

    // Per-stage record carried down the pipe.
    typedef struct packed {
        logic          valid;
        logic          se_to_reg;
        logic          write_reg;
        logic [RW-1:0] rd;
    } stage_t;

    ctrl_t          id_ctrl;
    logic           id_is_add;
    logic           squash;
    logic           accepted;
    logic           ex_hit_a;
    logic           ex_hit_b;
    logic           wb_hit_a;
    logic           wb_hit_b;
    logic [1:0]     fwd_a_d;
    logic [1:0]     fwd_b_d;
    stage_t         ex_q;
    stage_t         wb_q;
    logic [1:0]     ex_fwd_a_q;
    logic [1:0]     ex_fwd_b_q;
    logic [CNTW-1:0] retired_q;

    a3_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode (opcode),
        .ctrl   (id_ctrl),
        .is_add (id_is_add)
    );

    // An instruction moves into EX only when valid, not stalled and not the
    // slot shadowed by a just-taken jump.
    assign accepted = instr_valid & ~stall_in & ~squash;
    assign PCSrc    = accepted & id_ctrl.PCSrc;
    assign hold_out = stall_in;

    // Producer matches against the instructions currently in EX and WB.
    assign ex_hit_a = ex_q.valid & ex_q.write_reg & (rs1 == ex_q.rd);
    assign ex_hit_b = ex_q.valid & ex_q.write_reg & (rs2 == ex_q.rd);
    assign wb_hit_a = wb_q.valid & wb_q.write_reg & (rs1 == wb_q.rd);
    assign wb_hit_b = wb_q.valid & wb_q.write_reg & (rs2 == wb_q.rd);

    // Forwarding selects are only meaningful for ADD; other opcodes read the regfile.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_is_add) begin
            fwd_a_d = fwd_select(ex_hit_a, wb_hit_a);
            fwd_b_d = fwd_select(ex_hit_b, wb_hit_b);
        end
    end

    // Squash flag: armed by a taken jump, consumed by the next unstalled valid slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            squash <= 1'b0;
        end else if (PCSrc) begin
            squash <= 1'b1;
        end else if (squash && instr_valid && !stall_in) begin
            squash <= 1'b0;
        end
    end

    // EX register: loads the accepted instruction, otherwise a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_fwd_a_q <= FWD_RF;
            ex_fwd_b_q <= FWD_RF;
        end else if (accepted) begin
            ex_q.valid     <= 1'b1;
            ex_q.se_to_reg <= id_ctrl.SEtoReg;
            ex_q.write_reg <= id_ctrl.WriteReg;
            ex_q.rd        <= rd;
            ex_fwd_a_q     <= fwd_a_d;
            ex_fwd_b_q     <= fwd_b_d;
        end else begin
            ex_q       <= '0;
            ex_fwd_a_q <= FWD_RF;
            ex_fwd_b_q <= FWD_RF;
        end
    end

    // WB register: always advances from EX, stall or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= ex_q;
        end
    end

    // Retired counter: one per valid instruction leaving WB, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (wb_q.valid) begin
            retired_q <= retired_q + CNTW'(1);
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_SEtoReg  = ex_q.se_to_reg;
    assign ex_WriteReg = ex_q.write_reg;
    assign ex_rd       = ex_q.rd;
    assign ex_fwd_a    = ex_fwd_a_q;
    assign ex_fwd_b    = ex_fwd_b_q;
    assign wb_valid    = wb_q.valid;
    assign wb_SEtoReg  = wb_q.se_to_reg;
    assign wb_WriteReg = wb_q.write_reg;
    assign wb_rd       = wb_q.rd;
    assign retired     = retired_q;

endmodule

// File: tb/tb_a3_pipelined_control_unit.sv
// Self-checking bench for a3_pipelined_control_unit: directed vector table,
// hand-written reset and counter-wrap sequences, then random stimulus against
// a history-based reference model.
module tb_a3_pipelined_control_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        stall_in;

    logic        hold_out, PCSrc, ex_valid, ex_SEtoReg, ex_WriteReg;
    logic [2:0]  ex_rd, wb_rd;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic        wb_valid, wb_SEtoReg, wb_WriteReg;
    logic [15:0] retired;

    logic        w_hold_out, w_PCSrc, w_ex_valid, w_ex_SEtoReg, w_ex_WriteReg;
    logic [2:0]  w_ex_rd, w_wb_rd;
    logic [1:0]  w_ex_fwd_a, w_ex_fwd_b;
    logic        w_wb_valid, w_wb_SEtoReg, w_wb_WriteReg;
    logic [3:0]  w_retired;

    a3_pipelined_control_unit dut (
        .clk (clk), .rst_n (rst_n), .instr_valid (instr_valid), .opcode (opcode),
        .rd (rd), .rs1 (rs1), .rs2 (rs2), .stall_in (stall_in),
        .hold_out (hold_out), .PCSrc (PCSrc), .ex_valid (ex_valid),
        .ex_SEtoReg (ex_SEtoReg), .ex_WriteReg (ex_WriteReg), .ex_rd (ex_rd),
        .ex_fwd_a (ex_fwd_a), .ex_fwd_b (ex_fwd_b), .wb_valid (wb_valid),
        .wb_SEtoReg (wb_SEtoReg), .wb_WriteReg (wb_WriteReg), .wb_rd (wb_rd),
        .retired (retired)
    );

    a3_pipelined_control_unit #(.OPW (3), .RW (3), .CNTW (4)) dut_w (
        .clk (clk), .rst_n (rst_n), .instr_valid (instr_valid), .opcode (opcode),
        .rd (rd), .rs1 (rs1), .rs2 (rs2), .stall_in (stall_in),
        .hold_out (w_hold_out), .PCSrc (w_PCSrc), .ex_valid (w_ex_valid),
        .ex_SEtoReg (w_ex_SEtoReg), .ex_WriteReg (w_ex_WriteReg), .ex_rd (w_ex_rd),
        .ex_fwd_a (w_ex_fwd_a), .ex_fwd_b (w_ex_fwd_b), .wb_valid (w_wb_valid),
        .wb_SEtoReg (w_wb_SEtoReg), .wb_WriteReg (w_wb_WriteReg), .wb_rd (w_wb_rd),
        .retired (w_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[0] is what entered EX at the last edge, hist[1] the one before (now in WB).
    // Everything ever accepted minus what is still in flight has retired.
    typedef struct packed {
        bit       v;
        bit       se;
        bit       wr;
        bit [2:0] rd;
        bit [1:0] fa;
        bit [1:0] fb;
    } slot_t;

    slot_t       hist[$];
    int unsigned n_acc;
    bit          sq;
    bit          live;
    bit          c_r, c_iv, c_st, c_acc, c_j;
    slot_t       c_slot;

    function automatic bit [1:0] fwd_of(input bit [2:0] rs, input slot_t ex_s, input slot_t wb_s);
        if (ex_s.v && ex_s.wr && ex_s.rd == rs) return 2'd1;
        if (wb_s.v && wb_s.wr && wb_s.rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        hist.delete();
        hist.push_back(slot_t'(0));
        hist.push_back(slot_t'(0));
        n_acc = 0;
        sq    = 1'b0;
    endtask

    // Drive one cycle's inputs, then compare every output with the model.
    task automatic apply(input bit r, input bit iv, input bit [2:0] op, input bit [2:0] d,
                         input bit [2:0] s1, input bit [2:0] s2, input bit st);
        slot_t       ex_s;
        slot_t       wb_s;
        int unsigned exp_ret;
        rst_n = r; instr_valid = iv; opcode = op; rd = d; rs1 = s1; rs2 = s2; stall_in = st;
        #1;
        ex_s  = hist[0];
        wb_s  = hist[1];
        c_r   = r;
        c_iv  = iv;
        c_st  = st;
        c_acc = iv && !st && !sq;
        c_j   = c_acc && (op == 3'd3);
        c_slot = slot_t'(0);
        if (c_acc) begin
            c_slot.v  = 1'b1;
            c_slot.se = (op == 3'd0);
            c_slot.wr = (op == 3'd0) || (op == 3'd1);
            c_slot.rd = d;
            if (op == 3'd1) begin
                c_slot.fa = fwd_of(s1, ex_s, wb_s);
                c_slot.fb = fwd_of(s2, ex_s, wb_s);
            end
        end
        if (live) begin
            exp_ret = n_acc - 32'(ex_s.v) - 32'(wb_s.v);
            check("m_pcsrc",       32'(PCSrc),       32'(c_j));
            check("m_hold",        32'(hold_out),    32'(st));
            check("m_ex_valid",    32'(ex_valid),    32'(ex_s.v));
            check("m_ex_setoreg",  32'(ex_SEtoReg),  32'(ex_s.se));
            check("m_ex_writereg", 32'(ex_WriteReg), 32'(ex_s.wr));
            check("m_ex_fwd_a",    32'(ex_fwd_a),    32'(ex_s.fa));
            check("m_ex_fwd_b",    32'(ex_fwd_b),    32'(ex_s.fb));
            if (!(ex_s.v && !ex_s.wr)) check("m_ex_rd", 32'(ex_rd), 32'(ex_s.rd));
            check("m_wb_valid",    32'(wb_valid),    32'(wb_s.v));
            check("m_wb_setoreg",  32'(wb_SEtoReg),  32'(wb_s.se));
            check("m_wb_writereg", 32'(wb_WriteReg), 32'(wb_s.wr));
            if (!(wb_s.v && !wb_s.wr)) check("m_wb_rd", 32'(wb_rd), 32'(wb_s.rd));
            check("m_retired",     32'(retired),     exp_ret % 65536);
            check("m_retired_w4",  32'(w_retired),   exp_ret % 16);
        end
    endtask

    // Clock edge, then move the model forward by the same rules.
    task automatic advance();
        @(posedge clk);
        #1;
        if (!c_r) begin
            model_clear();
            live = 1'b1;
        end else begin
            hist.push_front(c_slot);
            void'(hist.pop_back());
            if (c_acc) n_acc++;
            if (c_j) sq = 1'b1;
            else if (sq && c_iv && !c_st) sq = 1'b0;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int iv, op, rd, rs1, rs2, st;
        int pc, hold, exv, exrd, fa, fb, wbv, wbrd, wbwr, ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int iv, op, d, s1, s2, st,
                                input int pc, hold, exv, exrd, fa, fb, wbv, wbrd, wbwr, ret);
        vec_t v;
        v.iv = iv; v.op = op; v.rd = d; v.rs1 = s1; v.rs2 = s2; v.st = st;
        v.pc = pc; v.hold = hold; v.exv = exv; v.exrd = exrd; v.fa = fa; v.fb = fb;
        v.wbv = wbv; v.wbrd = wbrd; v.wbwr = wbwr; v.ret = ret;
        return v;
    endfunction

    initial begin
        bit [2:0] legal_ops[3];
        bit [2:0] op;
        n_chk = 0;
        n_pass = 0;
        live = 1'b0;
        model_clear();
        legal_ops[0] = 3'd0; legal_ops[1] = 3'd1; legal_ops[2] = 3'd3;

        //                 iv op rd s1 s2 st  pc hd exv exrd fa fb wbv wbrd wbwr ret
        // LI r1; ADD r2<-r1,r1 : EX forwards both operands, WB shows r2 at cycle 3
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 1, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 1, 1));
        // LI r3; NOP; ADD r4<-r3,r0 : WB forward on A, regfile on B
        tbl.push_back(mk(1, 0, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0,  0, 0, 1, 3, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 4, 3, 0, 0,  0, 0, 1, 0, 0, 0, 1, 3, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 4, 2, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 4, 1, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        // J; LI r5 squashed, only the J retires
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        // J; 3 stalled cycles with LI presented; squash survives the stall
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 0, 5, 0, 0, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 0, 5, 0, 0, 1,  0, 1, 0, 0, 0, 0, 1, 0, 0, 6));
        tbl.push_back(mk(1, 0, 5, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 5, 0, 0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 5, 1, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        // J under stall: no redirect until stall drops; idle slot keeps squash armed
        tbl.push_back(mk(1, 3, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0, 8));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
        // LI r1 twice then ADD on r1: EX wins over WB
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 9));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0, 9));
        tbl.push_back(mk(1, 1, 2, 1, 1, 0,  0, 0, 1, 1, 0, 0, 1, 1, 1, 9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 1, 1, 1, 1, 1, 10));

        // Initial reset, then reset-state checks
        apply(0, 0, 0, 0, 0, 0, 0); advance();
        apply(0, 0, 0, 0, 0, 0, 0); advance();
        apply(1, 0, 0, 0, 0, 0, 0);
        check("rst_ex_valid",  32'(ex_valid),    0);
        check("rst_ex_wr",     32'(ex_WriteReg), 0);
        check("rst_wb_valid",  32'(wb_valid),    0);
        check("rst_wb_rd",     32'(wb_rd),       0);
        check("rst_retired",   32'(retired),     0);
        check("rst_pcsrc",     32'(PCSrc),       0);
        check("rst_hold",      32'(hold_out),    0);
        advance();

        foreach (tbl[i]) begin
            apply(1'b1, 1'(tbl[i].iv), 3'(tbl[i].op), 3'(tbl[i].rd), 3'(tbl[i].rs1),
                  3'(tbl[i].rs2), 1'(tbl[i].st));
            check($sformatf("t%0d_pcsrc", i),    32'(PCSrc),       tbl[i].pc);
            check($sformatf("t%0d_hold", i),     32'(hold_out),    tbl[i].hold);
            check($sformatf("t%0d_ex_valid", i), 32'(ex_valid),    tbl[i].exv);
            check($sformatf("t%0d_ex_rd", i),    32'(ex_rd),       tbl[i].exrd);
            check($sformatf("t%0d_fwd_a", i),    32'(ex_fwd_a),    tbl[i].fa);
            check($sformatf("t%0d_fwd_b", i),    32'(ex_fwd_b),    tbl[i].fb);
            check($sformatf("t%0d_wb_valid", i), 32'(wb_valid),    tbl[i].wbv);
            check($sformatf("t%0d_wb_rd", i),    32'(wb_rd),       tbl[i].wbrd);
            check($sformatf("t%0d_wb_wr", i),    32'(wb_WriteReg), tbl[i].wbwr);
            check($sformatf("t%0d_retired", i),  32'(retired),     tbl[i].ret);
            advance();
        end

        // Reset with J in EX, ADD in WB and a squash armed: everything discarded
        apply(1, 1, 1, 3, 1, 2, 0); advance();
        apply(1, 1, 3, 0, 0, 0, 0);
        check("r_pcsrc_j", 32'(PCSrc), 1);
        advance();
        apply(0, 0, 0, 0, 0, 0, 0);
        check("r_pre_ex_valid", 32'(ex_valid), 1);
        check("r_pre_wb_valid", 32'(wb_valid), 1);
        advance();
        apply(1, 1, 0, 6, 0, 0, 0);
        check("r_ex_valid",  32'(ex_valid),    0);
        check("r_ex_wr",     32'(ex_WriteReg), 0);
        check("r_ex_rd",     32'(ex_rd),       0);
        check("r_ex_fwd_a",  32'(ex_fwd_a),    0);
        check("r_wb_valid",  32'(wb_valid),    0);
        check("r_wb_wr",     32'(wb_WriteReg), 0);
        check("r_wb_rd",     32'(wb_rd),       0);
        check("r_retired",   32'(retired),     0);
        check("r_retired_w", 32'(w_retired),   0);
        advance();
        apply(1, 0, 0, 0, 0, 0, 0);
        check("r_next_ex_valid", 32'(ex_valid),    1);
        check("r_next_ex_rd",    32'(ex_rd),       6);
        check("r_next_ex_wr",    32'(ex_WriteReg), 1);
        advance();

        // 17 back-to-back LIs: the 4-bit counter passes 15 -> 0 -> 1
        apply(0, 0, 0, 0, 0, 0, 0); advance();
        for (int i = 0; i < 20; i++) begin
            apply(1, (i < 17), 0, 1, 0, 0, 0);
            if (i == 17) check("wrap_at_max", 32'(w_retired), 15);
            if (i == 18) check("wrap_to_zero", 32'(w_retired), 0);
            if (i == 19) begin
                check("wrap_to_one", 32'(w_retired), 1);
                check("wrap_wide",   32'(retired),   17);
            end
            advance();
        end

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
            else op = legal_ops[$urandom_range(0, 2)];
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), op,
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
